// File: rtl/cla_arbiter_if.sv
// Bus bundle between the clients, the arbiter and the shared adder core.
// The slave modport is the arbiter's view; master is the clients/adder side.
interface cla_arbiter_if #(
    parameter int unsigned W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         add_valid;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W:0]   add_sum;
    logic         rsp0_valid;
    logic [W:0]   rsp0_data;
    logic         rsp1_valid;
    logic [W:0]   rsp1_data;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  add_sum,
        output req0_ready, req1_ready,
        output add_valid, add_a, add_b,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output add_sum,
        input  req0_ready, req1_ready,
        input  add_valid, add_a, add_b,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/cla_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between two requesters.
// A tag pipe matched to the adder latency routes each sum back to its issuer.
module cla_arbiter #(
    parameter int unsigned W       = 16,
    parameter int unsigned LAT     = 3,
    parameter int unsigned MAX_OUT = 4
) (
    input logic clk,
    input logic rst,
    cla_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic          last_q;
    logic [CW-1:0] out0_q, out0_d;
    logic [CW-1:0] out1_q, out1_d;
    logic [LAT:0]  tag_vld_q;
    logic [LAT:0]  tag_id_q;
    logic          add_valid_q;
    logic [W-1:0]  add_a_q, add_b_q;
    logic          rsp0_valid_q, rsp1_valid_q;
    logic [W:0]    rsp0_data_q, rsp1_data_q;

    logic elig0, elig1, gnt0, gnt1, acc;

    // Grant: single eligible wins; on a tie the requester not named by last_q wins.
    always_comb begin
        elig0 = bus.req0_valid && (out0_q < CW'(MAX_OUT));
        elig1 = bus.req1_valid && (out1_q < CW'(MAX_OUT));
        gnt0  = elig0 && (!elig1 || last_q);
        gnt1  = elig1 && (!elig0 || !last_q);
        acc   = gnt0 || gnt1;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Outstanding counters: accept and response in the same cycle cancel out.
    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        if (gnt0 && !rsp0_valid_q && out0_q < CW'(MAX_OUT)) begin
            out0_d = out0_q + CW'(1);
        end else if (!gnt0 && rsp0_valid_q && out0_q != '0) begin
            out0_d = out0_q - CW'(1);
        end
        if (gnt1 && !rsp1_valid_q && out1_q < CW'(MAX_OUT)) begin
            out1_d = out1_q + CW'(1);
        end else if (!gnt1 && rsp1_valid_q && out1_q != '0) begin
            out1_d = out1_q - CW'(1);
        end
    end

    // Arbitration state: round-robin pointer and outstanding counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            if (acc) begin
                last_q <= gnt1;
            end
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

    // Issue stage: register the granted operands; they hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            add_valid_q <= acc;
            if (gnt0) begin
                add_a_q <= bus.req0_a;
                add_b_q <= bus.req0_b;
            end else if (gnt1) begin
                add_a_q <= bus.req1_a;
                add_b_q <= bus.req1_b;
            end
        end
    end

    // Tag pipe: stage 0 lines up with add_valid, stage LAT with add_sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[LAT-1:0], acc};
            tag_id_q  <= {tag_id_q[LAT-1:0], gnt1};
        end
    end

    // Response stage: capture the sum for the tail's owner; data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            rsp0_valid_q <= tag_vld_q[LAT] && !tag_id_q[LAT];
            rsp1_valid_q <= tag_vld_q[LAT] && tag_id_q[LAT];
            if (tag_vld_q[LAT] && !tag_id_q[LAT]) begin
                rsp0_data_q <= bus.add_sum;
            end
            if (tag_vld_q[LAT] && tag_id_q[LAT]) begin
                rsp1_data_q <= bus.add_sum;
            end
        end
    end

    assign bus.add_valid  = add_valid_q;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_data  = rsp1_data_q;
endmodule

// File: tb/tb_cla_arbiter.sv
// Randomized bench for cla_arbiter: a transaction-level model predicts grants,
// outstanding counts and in-order responses; the bench also plays the adder.
module tb_cla_arbiter;
    localparam int W       = 16;
    localparam int LAT     = 3;
    localparam int MAX_OUT = 4;

    logic clk;
    logic rst;

    cla_arbiter_if #(.W(W)) bus ();

    cla_arbiter #(.W(W), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder core: LAT-cycle pipe of full-width sums.
    logic [W:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.add_sum = pipe[LAT-1];

    typedef struct {
        int         id;
        logic [W:0] sum;
        int         due;
    } exp_t;

    exp_t         exp_q[$];
    int           cnt[2];
    int           last_m;
    int           cyc;
    logic [W:0]   last_data[2];
    bit           pa_valid;
    logic [W-1:0] pa_a, pa_b;
    int           n_checks;
    int           n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cnt[0] = 0;
        cnt[1] = 0;
        last_m = 1;
        last_data[0] = '0;
        last_data[1] = '0;
        pa_valid = 1'b0;
        pa_a = '0;
        pa_b = '0;
    endtask

    // One clock cycle: drive inputs, check every output against the model, update model.
    task automatic drive_cycle(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        bit e0, e1, g0, g1, p0, p1;
        logic [W:0] d;
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        #1;
        e0 = v0 && (cnt[0] < MAX_OUT);
        e1 = v1 && (cnt[1] < MAX_OUT);
        g0 = e0 && (!e1 || last_m == 1);
        g1 = e1 && (!e0 || last_m == 0);
        check_eq("ready0", 32'(bus.req0_ready), 32'(g0));
        check_eq("ready1", 32'(bus.req1_ready), 32'(g1));
        check_eq("add_valid", 32'(bus.add_valid), 32'(pa_valid));
        check_eq("add_a", 32'(bus.add_a), 32'(pa_a));
        check_eq("add_b", 32'(bus.add_b), 32'(pa_b));
        p0 = 1'b0;
        p1 = 1'b0;
        d  = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            d = exp_q[0].sum;
            if (exp_q[0].id == 0) p0 = 1'b1;
            else p1 = 1'b1;
            void'(exp_q.pop_front());
        end
        if (p0) last_data[0] = d;
        if (p1) last_data[1] = d;
        check_eq("rsp0_valid", 32'(bus.rsp0_valid), 32'(p0));
        check_eq("rsp1_valid", 32'(bus.rsp1_valid), 32'(p1));
        check_eq("rsp0_data", 32'(bus.rsp0_data), 32'(last_data[0]));
        check_eq("rsp1_data", 32'(bus.rsp1_data), 32'(last_data[1]));
        pa_valid = g0 || g1;
        if (g0) begin
            exp_q.push_back('{0, {1'b0, a0} + {1'b0, b0}, cyc + LAT + 2});
            cnt[0]++;
            last_m = 0;
            pa_a = a0;
            pa_b = b0;
        end
        if (g1) begin
            exp_q.push_back('{1, {1'b0, a1} + {1'b0, b1}, cyc + LAT + 2});
            cnt[1]++;
            last_m = 1;
            pa_a = a1;
            pa_b = b1;
        end
        if (p0) cnt[0]--;
        if (p1) cnt[1]--;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_add_valid", 32'(bus.add_valid), 32'd0);
        check_eq("rst_add_a", 32'(bus.add_a), 32'd0);
        check_eq("rst_add_b", 32'(bus.add_b), 32'd0);
        check_eq("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check_eq("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check_eq("rst_rsp0_data", 32'(bus.rsp0_data), 32'd0);
        check_eq("rst_rsp1_data", 32'(bus.rsp1_data), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        model_clear();
        do_reset();

        // Single request, no carry.
        drive_cycle(1'b1, 16'h6A98, 16'h2A9A, 1'b0, '0, '0);
        idle(5);
        check_eq("single_data", 32'(bus.rsp0_data), 32'h09532);
        idle(2);

        // Carry-out on requester 1.
        drive_cycle(1'b0, '0, '0, 1'b1, 16'hD53C, 16'hFD35);
        idle(5);
        check_eq("carry_data", 32'(bus.rsp1_data), 32'h1D271);
        idle(2);

        // Contention straight out of reset: 0 first, then alternating.
        do_reset();
        check_eq("tie_last_reset", 32'(dut.last_q), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom));
        end
        idle(8);

        // Saturation of requester 0 with requester 1 idle.
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, '0, '0);
        idle(8);

        // Reset with three requests in flight; nothing may come back for them.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, '0, '0);
        do_reset();
        idle(8);
        drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, '0, '0);
        idle(5);
        check_eq("post_reset_data", 32'(bus.rsp0_data), 32'h10000);
        idle(2);

        // Random traffic at varying request densities.
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 250; i++) begin
                drive_cycle(($urandom_range(0, 3) <= seg), 16'($urandom), 16'($urandom),
                            ($urandom_range(0, 3) < 3 - seg + 1), 16'($urandom), 16'($urandom));
            end
        end
        idle(8);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
